// File: rtl/tick_counter_pkg.sv
// Shared mode constants and divider helpers for tick_counter.
package tick_counter_pkg;

  localparam int MODE_UP_WRAP   = 0;
  localparam int MODE_DOWN_WRAP = 1;
  localparam int MODE_BOUNCE    = 2;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return (tick_hz > 0) ? clk_hz / tick_hz : 0;
  endfunction

  // Width is kept at least 1 so a bad DIV still elaborates far enough to report.
  function automatic int calc_pw(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..DIV-1 divider; STB flags the last count while enabled.
module tick_prescaler
  import tick_counter_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic EN,
  input  logic CLR,
  output logic STB
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PW  = calc_pw(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("tick_prescaler: CLK_HZ/TICK_HZ must be at least 2");
    end
  endgenerate

  logic [PW-1:0] cnt;

  assign STB = EN && (cnt == LAST);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
    end else if (CLR) begin
      cnt <= '0;
    end else if (EN) begin
      cnt <= STB ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tick_counter.sv
// Divided-clock counter with up-wrap, down-wrap and bounce modes, load and strobes.
// Define TICK_COUNTER_SYNC_EN to pass EN and LOAD through two-flop synchronisers.
module tick_counter
  import tick_counter_pkg::*;
#(
  parameter int              CLK_HZ    = 50_000_000,
  parameter int              TICK_HZ   = 1,
  parameter int              WIDTH     = 3,
  parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
  parameter int              MODE      = MODE_UP_WRAP
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] COUNT,
  output logic             TICK,
  output logic             WRAP,
  output logic             DIR_UP
);

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("tick_counter: WIDTH must be 1..32");
    end
    if (MAX_COUNT < 1 || MAX_COUNT > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
      $error("tick_counter: MAX_COUNT out of range");
    end
    if (MODE < MODE_UP_WRAP || MODE > MODE_BOUNCE) begin : g_bad_mode
      $error("tick_counter: MODE must be 0, 1 or 2");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_V     = MAX_COUNT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_COUNT = (MODE == MODE_DOWN_WRAP) ? MAX_V : '0;
  localparam logic             RST_DIR   = (MODE != MODE_DOWN_WRAP);

  logic en_i, load_i;

`ifdef TICK_COUNTER_SYNC_EN
  logic [1:0] en_sync, load_sync;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      en_sync   <= '0;
      load_sync <= '0;
    end else begin
      en_sync   <= {en_sync[0], EN};
      load_sync <= {load_sync[0], LOAD};
    end
  end

  assign en_i   = en_sync[1];
  assign load_i = load_sync[1];
`else
  assign en_i   = EN;
  assign load_i = LOAD;
`endif

  logic stb, adv;

  tick_prescaler #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_prescaler (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .EN      (en_i),
    .CLR     (load_i),
    .STB     (stb)
  );

  // A load in the same cycle swallows the advance rather than deferring it.
  assign adv = stb && !load_i;

  logic [WIDTH-1:0] count, nxt_count, load_clamped;
  logic             dir, nxt_dir, nxt_wrap, tick, wrap;

  assign load_clamped = (LOAD_VAL > MAX_V) ? MAX_V : LOAD_VAL;

  always_comb begin
    nxt_count = count;
    nxt_dir   = dir;
    nxt_wrap  = 1'b0;
    case (MODE)
      MODE_DOWN_WRAP: begin
        if (count == '0) begin
          nxt_count = MAX_V;
          nxt_wrap  = 1'b1;
        end else begin
          nxt_count = count - 1'b1;
        end
      end
      MODE_BOUNCE: begin
        if (dir) begin
          nxt_count = count + 1'b1;
          if (nxt_count == MAX_V) begin
            nxt_dir  = 1'b0;
            nxt_wrap = 1'b1;
          end
        end else begin
          nxt_count = count - 1'b1;
          if (nxt_count == '0) begin
            nxt_dir  = 1'b1;
            nxt_wrap = 1'b1;
          end
        end
      end
      default: begin
        if (count >= MAX_V) begin
          nxt_count = '0;
          nxt_wrap  = 1'b1;
        end else begin
          nxt_count = count + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= RST_COUNT;
      dir   <= RST_DIR;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else if (load_i) begin
      count <= load_clamped;
      tick  <= 1'b0;
      wrap  <= 1'b0;
      // Loading an endpoint in bounce mode points the count back into range.
      if (MODE == MODE_BOUNCE) begin
        if (load_clamped == MAX_V) dir <= 1'b0;
        else if (load_clamped == '0) dir <= 1'b1;
      end
    end else if (adv) begin
      count <= nxt_count;
      dir   <= nxt_dir;
      tick  <= 1'b1;
      wrap  <= nxt_wrap;
    end else begin
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end
  end

  assign COUNT  = count;
  assign TICK   = tick;
  assign WRAP   = wrap;
  assign DIR_UP = dir;

endmodule

// File: tb/tb_tick_counter.sv
// Directed bench: three tick_counter instances (up, bounce, down) on shared inputs.
module tb_tick_counter;

`ifdef TICK_COUNTER_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_val = 3'd0;

  logic [2:0] cnt_up, cnt_bn, cnt_dn;
  logic       tick_up, tick_bn, tick_dn;
  logic       wrap_up, wrap_bn, wrap_dn;
  logic       d_up, d_bn, d_dn;

  int n_run = 0;
  int n_fail = 0;

  // Bounce, MAX_COUNT = 5: values, WRAP and DIR_UP after each of the first 11 ticks.
  logic [2:0] bn_seq  [0:10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
  logic       bn_wrap [0:10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       bn_dir  [0:10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  tick_counter #(.CLK_HZ(8), .TICK_HZ(1), .WIDTH(3), .MAX_COUNT(7), .MODE(0)) u_up (
    .CLOCK_50(clk), .RESET_N(rst_n), .EN(en), .LOAD(load), .LOAD_VAL(load_val),
    .COUNT(cnt_up), .TICK(tick_up), .WRAP(wrap_up), .DIR_UP(d_up));

  tick_counter #(.CLK_HZ(8), .TICK_HZ(1), .WIDTH(3), .MAX_COUNT(5), .MODE(2)) u_bn (
    .CLOCK_50(clk), .RESET_N(rst_n), .EN(en), .LOAD(load), .LOAD_VAL(load_val),
    .COUNT(cnt_bn), .TICK(tick_bn), .WRAP(wrap_bn), .DIR_UP(d_bn));

  tick_counter #(.CLK_HZ(8), .TICK_HZ(1), .WIDTH(3), .MAX_COUNT(7), .MODE(1)) u_dn (
    .CLOCK_50(clk), .RESET_N(rst_n), .EN(en), .LOAD(load), .LOAD_VAL(load_val),
    .COUNT(cnt_dn), .TICK(tick_dn), .WRAP(wrap_dn), .DIR_UP(d_dn));

  task automatic step(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; load = 1'b0; load_val = 3'd0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_run++; if (cnt_up !== 3'd0) begin n_fail++; $display("FAIL reset_cnt_up: got %0d want 0", cnt_up); end
    n_run++; if (cnt_bn !== 3'd0) begin n_fail++; $display("FAIL reset_cnt_bn: got %0d want 0", cnt_bn); end
    n_run++; if (cnt_dn !== 3'd7) begin n_fail++; $display("FAIL reset_cnt_dn: got %0d want 7", cnt_dn); end
    n_run++; if ({d_up, d_bn, d_dn} !== 3'b110) begin n_fail++; $display("FAIL reset_dir: got %b want 110", {d_up, d_bn, d_dn}); end
    n_run++; if ({tick_up, tick_bn, tick_dn, wrap_up, wrap_bn, wrap_dn} !== 6'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 000000", {tick_up, tick_bn, tick_dn, wrap_up, wrap_bn, wrap_dn});
    end
  endtask

  task automatic test_up_wrap();
    do_reset();
    en = 1'b1;
    step(SL);
    for (int k = 1; k <= 8; k++) begin
      for (int c = 0; c < 7; c++) begin
        step(1);
        n_run++; if (tick_up !== 1'b0) begin n_fail++; $display("FAIL up_no_tick k=%0d c=%0d: got %b want 0", k, c, tick_up); end
      end
      step(1);
      n_run++; if (tick_up !== 1'b1) begin n_fail++; $display("FAIL up_tick k=%0d: got %b want 1", k, tick_up); end
      n_run++; if (cnt_up !== 3'(k % 8)) begin n_fail++; $display("FAIL up_cnt k=%0d: got %0d want %0d", k, cnt_up, k % 8); end
      n_run++; if (wrap_up !== (k == 8)) begin n_fail++; $display("FAIL up_wrap k=%0d: got %b want %b", k, wrap_up, k == 8); end
      n_run++; if (d_up !== 1'b1) begin n_fail++; $display("FAIL up_dir k=%0d: got %b want 1", k, d_up); end
    end
    step(1);
    n_run++; if (tick_up !== 1'b0 || wrap_up !== 1'b0) begin
      n_fail++; $display("FAIL up_strobe_width: got tick=%b wrap=%b want 0 0", tick_up, wrap_up);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    en = 1'b1;
    step(SL);
    for (int k = 0; k < 11; k++) begin
      step(8);
      n_run++; if (tick_bn !== 1'b1) begin n_fail++; $display("FAIL bn_tick k=%0d: got %b want 1", k, tick_bn); end
      n_run++; if (cnt_bn !== bn_seq[k]) begin n_fail++; $display("FAIL bn_cnt k=%0d: got %0d want %0d", k, cnt_bn, bn_seq[k]); end
      n_run++; if (wrap_bn !== bn_wrap[k]) begin n_fail++; $display("FAIL bn_wrap k=%0d: got %b want %b", k, wrap_bn, bn_wrap[k]); end
      n_run++; if (d_bn !== bn_dir[k]) begin n_fail++; $display("FAIL bn_dir k=%0d: got %b want %b", k, d_bn, bn_dir[k]); end
    end
  endtask

  task automatic test_down_load();
    do_reset();
    en = 1'b1;
    step(7);
    load = 1'b1; load_val = 3'd6;
    step(1);
    load = 1'b0;
    step(SL);
    n_run++; if (cnt_dn !== 3'd6) begin n_fail++; $display("FAIL dl_cnt_dn: got %0d want 6", cnt_dn); end
    n_run++; if (tick_dn !== 1'b0) begin n_fail++; $display("FAIL dl_no_tick: got %b want 0", tick_dn); end
    n_run++; if (cnt_up !== 3'd6) begin n_fail++; $display("FAIL dl_cnt_up: got %0d want 6", cnt_up); end
    n_run++; if (cnt_bn !== 3'd5 || d_bn !== 1'b0) begin
      n_fail++; $display("FAIL dl_clamp_bn: got cnt=%0d dir=%b want 5 0", cnt_bn, d_bn);
    end
    for (int c = 0; c < 7; c++) begin
      step(1);
      n_run++; if (tick_dn !== 1'b0) begin n_fail++; $display("FAIL dl_wait c=%0d: got %b want 0", c, tick_dn); end
    end
    step(1);
    n_run++; if (tick_dn !== 1'b1 || cnt_dn !== 3'd5) begin
      n_fail++; $display("FAIL dl_next_tick: got tick=%b cnt=%0d want 1 5", tick_dn, cnt_dn);
    end
    n_run++; if (cnt_bn !== 3'd4 || wrap_bn !== 1'b0) begin
      n_fail++; $display("FAIL dl_bn_next: got cnt=%0d wrap=%b want 4 0", cnt_bn, wrap_bn);
    end
    n_run++; if (cnt_up !== 3'd7 || wrap_up !== 1'b0) begin
      n_fail++; $display("FAIL dl_up_next: got cnt=%0d wrap=%b want 7 0", cnt_up, wrap_up);
    end
  endtask

  task automatic test_clamp_endpoints();
    do_reset();
    load = 1'b1; load_val = 3'd7;
    step(1);
    load = 1'b0;
    step(SL);
    n_run++; if (cnt_bn !== 3'd5 || d_bn !== 1'b0) begin
      n_fail++; $display("FAIL cl_bn: got cnt=%0d dir=%b want 5 0", cnt_bn, d_bn);
    end
    n_run++; if (cnt_up !== 3'd7 || cnt_dn !== 3'd7) begin
      n_fail++; $display("FAIL cl_up_dn: got up=%0d dn=%0d want 7 7", cnt_up, cnt_dn);
    end
    en = 1'b1;
    step(SL + 8);
    n_run++; if (tick_bn !== 1'b1 || cnt_bn !== 3'd4 || wrap_bn !== 1'b0) begin
      n_fail++; $display("FAIL cl_bn_tick: got tick=%b cnt=%0d wrap=%b want 1 4 0", tick_bn, cnt_bn, wrap_bn);
    end
    n_run++; if (cnt_up !== 3'd0 || wrap_up !== 1'b1) begin
      n_fail++; $display("FAIL cl_up_wrap: got cnt=%0d wrap=%b want 0 1", cnt_up, wrap_up);
    end
    n_run++; if (cnt_dn !== 3'd6 || wrap_dn !== 1'b0) begin
      n_fail++; $display("FAIL cl_dn_tick: got cnt=%0d wrap=%b want 6 0", cnt_dn, wrap_dn);
    end
    load = 1'b1; load_val = 3'd0;
    step(1);
    load = 1'b0;
    step(SL);
    n_run++; if (cnt_bn !== 3'd0 || d_bn !== 1'b1) begin
      n_fail++; $display("FAIL ld0_bn: got cnt=%0d dir=%b want 0 1", cnt_bn, d_bn);
    end
    step(8);
    n_run++; if (tick_bn !== 1'b1 || cnt_bn !== 3'd1 || wrap_bn !== 1'b0) begin
      n_fail++; $display("FAIL ld0_bn_tick: got tick=%b cnt=%0d wrap=%b want 1 1 0", tick_bn, cnt_bn, wrap_bn);
    end
    n_run++; if (cnt_dn !== 3'd7 || wrap_dn !== 1'b1) begin
      n_fail++; $display("FAIL ld0_dn_wrap: got cnt=%0d wrap=%b want 7 1", cnt_dn, wrap_dn);
    end
  endtask

  task automatic test_pause();
    do_reset();
    en = 1'b1;
    step(SL + 3);
    en = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      n_run++; if (tick_up !== 1'b0 || cnt_up !== 3'd0) begin
        n_fail++; $display("FAIL pause_hold c=%0d: got tick=%b cnt=%0d want 0 0", c, tick_up, cnt_up);
      end
    end
    en = 1'b1;
    step(4);
    n_run++; if (tick_up !== 1'b0) begin n_fail++; $display("FAIL pause_early: got %b want 0", tick_up); end
    step(1);
    n_run++; if (tick_up !== 1'b1 || cnt_up !== 3'd1) begin
      n_fail++; $display("FAIL pause_resume: got tick=%b cnt=%0d want 1 1", tick_up, cnt_up);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1'b1;
    step(SL + 35);
    n_run++; if (cnt_up !== 3'd4) begin n_fail++; $display("FAIL rm_pre: got %0d want 4", cnt_up); end
    #2;
    rst_n = 1'b0;
    #1;
    n_run++; if (cnt_up !== 3'd0 || tick_up !== 1'b0) begin
      n_fail++; $display("FAIL rm_async_up: got cnt=%0d tick=%b want 0 0", cnt_up, tick_up);
    end
    n_run++; if (cnt_dn !== 3'd7 || d_dn !== 1'b0) begin
      n_fail++; $display("FAIL rm_async_dn: got cnt=%0d dir=%b want 7 0", cnt_dn, d_dn);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(7 + SL);
    n_run++; if (tick_up !== 1'b0 || cnt_up !== 3'd0) begin
      n_fail++; $display("FAIL rm_no_pending: got tick=%b cnt=%0d want 0 0", tick_up, cnt_up);
    end
    step(1);
    n_run++; if (tick_up !== 1'b1 || cnt_up !== 3'd1) begin
      n_fail++; $display("FAIL rm_first_tick: got tick=%b cnt=%0d want 1 1", tick_up, cnt_up);
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_bounce();
    test_down_load();
    test_clamp_endpoints();
    test_pause();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_counter.md
Name: tick_counter

Overview:
- Parametrised successor to the board's fixed 1 Hz, 3-bit LED counter.
- Divides CLOCK_50 down to a configurable tick rate and drives a WIDTH-bit count with selectable counting mode.
- Adds synchronous load, count enable, a tick strobe and a terminal-count/turn-around strobe.
- Sits between the board clock and the LED/7-seg display logic at top level.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz.
- TICK_HZ, 1, count advance rate in Hz. DIV = CLK_HZ/TICK_HZ; elaboration error if DIV < 2.
- WIDTH, 3, count width in bits, 1..32.
- MAX_COUNT, 2**WIDTH-1, terminal value; must be ≥ 1 and ≤ 2**WIDTH-1.
- MODE, 0, counting mode: 0 = up-wrap, 1 = down-wrap, 2 = bounce (up/down ping-pong).

Ports:
- CLOCK_50, in, 1, system clock.
- RESET_N, in, 1, asynchronous active-low reset.
- EN, in, 1, count enable; low freezes both prescaler and count.
- LOAD, in, 1, synchronous load strobe.
- LOAD_VAL, in, WIDTH, value to load.
- COUNT, out, WIDTH, current count (registered).
- TICK, out, 1, one-cycle pulse, high in the cycle COUNT first shows a newly advanced value.
- WRAP, out, 1, one-cycle pulse coincident with TICK when the advance crossed the terminal point.
- DIR_UP, out, 1, current direction (1 = up). Constant in modes 0 and 1.

Behaviour:
- Reset (async assert, sync release):
  - prescaler = 0, TICK = 0, WRAP = 0.
  - COUNT = 0 in modes 0 and 2; COUNT = MAX_COUNT in mode 1.
  - DIR_UP = 1 in modes 0 and 2; DIR_UP = 0 in mode 1.
- Prescaler: counts 0..DIV-1 while EN = 1; holds value while EN = 0. Advance event = EN && prescaler == DIV-1 && !LOAD; on it the prescaler returns to 0.
- Latency: COUNT, TICK and WRAP update on the same edge as the advance event. TICK and WRAP are registered and high for exactly one cycle. First TICK after reset release occurs DIV cycles after the first EN-high edge.
- Mode 0: COUNT+1; at MAX_COUNT → 0 with WRAP = 1.
- Mode 1: COUNT-1; at 0 → MAX_COUNT with WRAP = 1.
- Mode 2:
  - DIR_UP = 1: COUNT+1; reaching MAX_COUNT sets DIR_UP = 0 and WRAP = 1 on that edge.
  - DIR_UP = 0: COUNT-1; reaching 0 sets DIR_UP = 1 and WRAP = 1.
  - Endpoints are held for one tick only, i.e. the sequence is 0,1,..,MAX,MAX-1,..,0,1.
- LOAD (priority over advance, ignores EN):
  - COUNT = LOAD_VAL, clamped to MAX_COUNT if larger.
  - prescaler = 0, TICK = 0, WRAP = 0 that cycle.
  - DIR_UP unchanged, except in mode 2 a load of MAX_COUNT forces DIR_UP = 0 and a load of 0 forces DIR_UP = 1.
- Simultaneous LOAD and advance: load wins; the advance is discarded, not deferred.
- EN drop mid-period: prescaler freezes; remaining cycles to the next tick are preserved across the pause.
- Reset mid-period: all state returns to reset values immediately, no pending tick.
- Arithmetic is WIDTH-bit unsigned; the prescaler is $clog2(DIV) bits. No overflow beyond MAX_COUNT is ever visible on COUNT.

Optional Feature:
- Macro: TICK_COUNTER_SYNC_EN.
- Defined: EN and LOAD pass through two-flop synchronisers (reset to 0) before use, for raw board keys/switches. All EN/LOAD responses slip by 2 cycles. LOAD_VAL is sampled in the same cycle as the synchronised LOAD.
- Undefined: EN and LOAD are used directly and are assumed synchronous to CLOCK_50.

Decomposition:
- Package tick_counter_pkg:
  - mode constants MODE_UP_WRAP = 0, MODE_DOWN_WRAP = 1, MODE_BOUNCE = 2;
  - a function computing DIV and prescaler width from CLK_HZ/TICK_HZ.
- Sub-module tick_prescaler (CLK_HZ, TICK_HZ): ports CLOCK_50, RESET_N, EN, CLR; output STB, asserted combinationally when EN && count == DIV-1. The top level owns the count, direction and strobe registers.

Test Plan (CLK_HZ=8, TICK_HZ=1, DIV=8, WIDTH=3 unless noted):
- Reset, then EN = 1 held, MODE 0, MAX_COUNT = 7 → TICK every 8 cycles; COUNT 1,2,..,7,0; WRAP only on the 7→0 edge; first TICK 8 cycles after the first EN edge.
- MODE 2, MAX_COUNT = 5 → COUNT 0,1,2,3,4,5,4,3,2,1,0,1; WRAP at 5 and at 0; DIR_UP toggles on those same edges.
- MODE 1, LOAD = 1 with LOAD_VAL = 6 at prescaler = 7, EN = 1 → COUNT = 6, no TICK; next TICK 8 cycles later, COUNT = 5.
- MAX_COUNT = 5, LOAD_VAL = 7 → COUNT clamps to 5. In mode 2 DIR_UP becomes 0 and the next tick gives 4.
- EN low for 20 cycles with prescaler at 3 → COUNT and prescaler frozen. After EN returns high, TICK follows 5 cycles later.
- RESET_N pulsed low asynchronously mid-period (COUNT = 4) → COUNT = 0 and TICK = 0 immediately. With TICK_COUNTER_SYNC_EN defined, the first TICK after EN rises arrives 10 cycles later.
